// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble writer for a 4-bit HD44780-style LCD: power-up init, E strobe
// timing and execution delays, behind a valid/ready byte interface.
module lcd_nibble_writer #(
    parameter int SETUP_CYC = 1,
    parameter int E_CYC     = 1,
    parameter int HOLD_CYC  = 1,
    parameter int EXEC_CYC  = 80,
    parameter int SLOW_CYC  = 3200,
    parameter int PWRUP_CYC = 80000,
    parameter int INIT1_CYC = 8200,
    parameter int INIT2_CYC = 200,
    parameter int INIT_EN   = 1
) (
    input  logic       refclk,
    input  logic       nreset,
    input  logic [7:0] din,
    input  logic       din_rs,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       init_done,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXD = max2(max2(max2(SETUP_CYC, E_CYC), max2(HOLD_CYC, EXEC_CYC)),
                               max2(max2(SLOW_CYC, PWRUP_CYC), max2(INIT1_CYC, INIT2_CYC)));
    localparam int CW = $clog2(MAXD + 1);

    // Every phase loads N-1 on entry and leaves on the edge after the count hits zero.
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] L_E     = CW'(E_CYC - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] L_SLOW  = CW'(SLOW_CYC - 1);
    localparam logic [CW-1:0] L_PWRUP = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] L_INIT1 = CW'(INIT1_CYC - 1);
    localparam logic [CW-1:0] L_INIT2 = CW'(INIT2_CYC - 1);

    localparam logic [2:0] PWRUP     = 3'd0;
    localparam logic [2:0] INIT_NIB  = 3'd1;
    localparam logic [2:0] INIT_WAIT = 3'd2;
    localparam logic [2:0] IDLE      = 3'd3;
    localparam logic [2:0] SETUP     = 3'd4;
    localparam logic [2:0] EHIGH     = 3'd5;
    localparam logic [2:0] HOLD      = 3'd6;
    localparam logic [2:0] EXEC      = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          brs_q, brs_d;
    logic          lo_q, lo_d;
    logic [1:0]    nib_idx_q, nib_idx_d;
    logic          init_done_q, init_done_d;
    logic [3:0]    lcd_data_q, lcd_data_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_e_q, lcd_e_d;

    logic          last;
    logic          accept;
    logic          slow_cmd;
    logic [CW-1:0] init_wait;

    assign last     = (cnt_q == '0);
    // Ready in the final EXEC cycle too, so a held byte is taken on the edge EXEC ends.
    assign din_ready = (state_q == IDLE) || ((state_q == EXEC) && last);
    assign accept   = din_valid && din_ready;
    assign slow_cmd = !brs_q && ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));

    assign init_done = init_done_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_e     = lcd_e_q;

    always_comb begin
        init_wait = L_EXEC;
        case (nib_idx_q)
            2'd0:    init_wait = L_INIT1;
            2'd1:    init_wait = L_INIT2;
            default: init_wait = L_EXEC;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        brs_d       = brs_q;
        lo_d        = lo_q;
        nib_idx_d   = nib_idx_q;
        init_done_d = init_done_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_e_d     = lcd_e_q;

        case (state_q)
            PWRUP: begin
                if (INIT_EN == 0) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else if (last) begin
                    state_d = INIT_NIB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            INIT_NIB: begin
                state_d    = SETUP;
                cnt_d      = L_SETUP;
                nib_idx_d  = 2'd0;
                lcd_data_d = 4'h3;
                lcd_rs_d   = 1'b0;
            end
            INIT_WAIT: begin
                if (!last) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (nib_idx_q == 2'd3) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d    = SETUP;
                    cnt_d      = L_SETUP;
                    nib_idx_d  = nib_idx_q + 2'd1;
                    lcd_data_d = (nib_idx_q == 2'd2) ? 4'h2 : 4'h3;
                    lcd_rs_d   = 1'b0;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = EHIGH;
                    cnt_d   = L_E;
                    lcd_e_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            EHIGH: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = L_HOLD;
                    lcd_e_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (!last) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!init_done_q) begin
                    state_d = INIT_WAIT;
                    cnt_d   = init_wait;
                end else if (!lo_q) begin
                    state_d    = SETUP;
                    cnt_d      = L_SETUP;
                    lo_d       = 1'b1;
                    lcd_data_d = byte_q[3:0];
                end else begin
                    state_d = EXEC;
                    cnt_d   = slow_cmd ? L_SLOW : L_EXEC;
                end
            end
            IDLE, EXEC: begin
                if (accept) begin
                    state_d    = SETUP;
                    cnt_d      = L_SETUP;
                    byte_d     = din;
                    brs_d      = din_rs;
                    lo_d       = 1'b0;
                    lcd_data_d = din[7:4];
                    lcd_rs_d   = din_rs;
                end else if (state_q == EXEC) begin
                    if (last) state_d = IDLE;
                    else      cnt_d   = cnt_q - CW'(1);
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge refclk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= PWRUP;
            cnt_q       <= L_PWRUP;
            byte_q      <= 8'h00;
            brs_q       <= 1'b0;
            lo_q        <= 1'b0;
            nib_idx_q   <= 2'd0;
            init_done_q <= 1'b0;
            lcd_data_q  <= 4'h0;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            brs_q       <= brs_d;
            lo_q        <= lo_d;
            nib_idx_q   <= nib_idx_d;
            init_done_q <= init_done_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with shortened power-up/init/slow delays;
// a second instance covers INIT_EN=0.
module tb_lcd_nibble_writer;

  localparam int P   = 200;
  localparam int W1  = 50;
  localparam int W2  = 20;
  localparam int EX  = 80;
  localparam int SL  = 300;
  localparam int INIT_CYC = P + 12 + W1 + W2 + 2 * EX;  // 442
  localparam int FAST_GAP = 6 + EX;                      // 86
  localparam int SLOW_GAP = 6 + SL;                      // 306

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_rs = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready, init_done, lcd_rs, lcd_e;
  logic [3:0] lcd_data;

  logic [7:0] din0 = 8'h00;
  logic       din0_rs = 1'b0;
  logic       din0_valid = 1'b0;
  logic       din0_ready, init0_done, lcd0_rs, lcd0_e;
  logic [3:0] lcd0_data;

  int checks = 0;
  int failures = 0;
  int cyc;

  int         rise_q[$];
  logic [3:0] nib_q[$];
  logic       rs_q[$];
  logic       stable_q[$];
  logic [3:0] rise_data;
  logic       stable_now;
  logic       e_prev = 1'b0;
  logic       e0_prev = 1'b0;
  int         e0_rises = 0;

  lcd_nibble_writer #(
    .SETUP_CYC(1), .E_CYC(1), .HOLD_CYC(1), .EXEC_CYC(EX), .SLOW_CYC(SL),
    .PWRUP_CYC(P), .INIT1_CYC(W1), .INIT2_CYC(W2), .INIT_EN(1)
  ) dut (
    .refclk(clk), .nreset(nreset), .din(din), .din_rs(din_rs), .din_valid(din_valid),
    .din_ready(din_ready), .init_done(init_done), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_e(lcd_e)
  );

  lcd_nibble_writer #(
    .SETUP_CYC(1), .E_CYC(1), .HOLD_CYC(1), .EXEC_CYC(EX), .SLOW_CYC(SL),
    .PWRUP_CYC(P), .INIT1_CYC(W1), .INIT2_CYC(W2), .INIT_EN(0)
  ) dut0 (
    .refclk(clk), .nreset(nreset), .din(din0), .din_rs(din0_rs), .din_valid(din0_valid),
    .din_ready(din0_ready), .init_done(init0_done), .lcd_data(lcd0_data), .lcd_rs(lcd0_rs),
    .lcd_e(lcd0_e)
  );

  // clock / cycle index (cyc = index of the most recent rising edge after release)
  always #5 clk = ~clk;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) cyc <= -1;
    else         cyc <= cyc + 1;
  end

  // strobe monitor: rise cycle, nibble/rs seen during hold, data stability while E high
  always @(negedge clk) begin
    if (!nreset) begin
      e_prev  = 1'b0;
      e0_prev = 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        rise_q.push_back(cyc);
        rise_data  = lcd_data;
        stable_now = 1'b1;
      end else if (lcd_e && (lcd_data !== rise_data)) begin
        stable_now = 1'b0;
      end
      if (!lcd_e && e_prev) begin
        nib_q.push_back(lcd_data);
        rs_q.push_back(lcd_rs);
        stable_q.push_back(stable_now && (lcd_data === rise_data));
      end
      if (lcd0_e && !e0_prev) e0_rises++;
      e_prev  = lcd_e;
      e0_prev = lcd0_e;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic clear_q();
    rise_q.delete();
    nib_q.delete();
    rs_q.delete();
    stable_q.delete();
  endtask

  task automatic expect_strobe(input string tag, input logic [3:0] nib, input logic rs,
                               input int rise_cyc);
    int r;
    check({tag, "_present"}, 32'(nib_q.size() > 0), 32'd1);
    if (nib_q.size() > 0) begin
      r = rise_q.pop_front();
      check({tag, "_nib"}, 32'(nib_q.pop_front()), 32'(nib));
      check({tag, "_rs"}, 32'(rs_q.pop_front()), 32'(rs));
      check({tag, "_stable"}, 32'(stable_q.pop_front()), 32'd1);
      check({tag, "_rise"}, 32'(r), 32'(rise_cyc));
    end
  endtask

  // Called at a negedge; returns accept edge and the edge din_ready next handshakes on.
  task automatic write_byte(input logic [7:0] d, input logic r, output int a, output int rdy);
    int n;
    din = d; din_rs = r; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 5000) begin @(negedge clk); n++; end
    a = cyc + 1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (!din_ready && n < 5000) begin @(negedge clk); n++; end
    rdy = cyc + 1;
    check("ready_timeout", 32'(n < 5000), 32'd1);
  endtask

  task automatic check_init(input string tag);
    wait_cyc(INIT_CYC - 1);
    check({tag, "_ready_before"}, 32'(din_ready), 32'd0);
    check({tag, "_done_before"}, 32'(init_done), 32'd0);
    check({tag, "_strobes"}, 32'(nib_q.size()), 32'd4);
    @(negedge clk);
    check({tag, "_ready_at"}, 32'(din_ready), 32'd1);
    check({tag, "_done_at"}, 32'(init_done), 32'd1);
    expect_strobe({tag, "_n0"}, 4'h3, 1'b0, P + 1);
    expect_strobe({tag, "_n1"}, 4'h3, 1'b0, P + 1 + 3 + W1);
    expect_strobe({tag, "_n2"}, 4'h3, 1'b0, P + 1 + 6 + W1 + W2);
    expect_strobe({tag, "_n3"}, 4'h2, 1'b0, P + 1 + 9 + W1 + W2 + EX);
  endtask

  initial begin
    int a, rdy, n;
    int acc[3];

    // reset values
    repeat (3) @(negedge clk);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst0_ready", 32'(din0_ready), 32'd0);
    nreset = 1'b1;

    // INIT_EN=0 instance is idle from the first edge
    wait_cyc(1);
    check("noinit_ready", 32'(din0_ready), 32'd1);
    check("noinit_done", 32'(init0_done), 32'd1);

    // power-up sequence
    check_init("init");

    // data byte 0x48
    clear_q();
    write_byte(8'h48, 1'b1, a, rdy);
    check("w48_gap", 32'(rdy - a), 32'(FAST_GAP));
    expect_strobe("w48_hi", 4'h4, 1'b1, a + 1);
    expect_strobe("w48_lo", 4'h8, 1'b1, a + 4);

    // clear command: slow wait
    write_byte(8'h01, 1'b0, a, rdy);
    check("c01_gap", 32'(rdy - a), 32'(SLOW_GAP));
    expect_strobe("c01_hi", 4'h0, 1'b0, a + 1);
    expect_strobe("c01_lo", 4'h1, 1'b0, a + 4);

    // boundaries of the slow-command set
    write_byte(8'h03, 1'b0, a, rdy);
    check("c03_gap", 32'(rdy - a), 32'(SLOW_GAP));
    write_byte(8'h04, 1'b0, a, rdy);
    check("c04_gap", 32'(rdy - a), 32'(FAST_GAP));
    write_byte(8'h02, 1'b1, a, rdy);
    check("d02_gap", 32'(rdy - a), 32'(FAST_GAP));
    write_byte(8'h80, 1'b0, a, rdy);
    check("c80_gap", 32'(rdy - a), 32'(FAST_GAP));
    expect_strobe("c03_hi", 4'h0, 1'b0, nib_q.size() > 0 ? rise_q[0] : 0);
    clear_q();

    // back-to-back with din_valid held high
    din_rs = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'h41 + 8'(i);
      n = 0;
      while (!din_ready && n < 5000) begin @(negedge clk); n++; end
      acc[i] = cyc + 1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'(FAST_GAP));
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'(FAST_GAP));
    n = 0;
    while (!din_ready && n < 5000) begin @(negedge clk); n++; end
    check("b2b_strobes", 32'(nib_q.size()), 32'd6);
    expect_strobe("b2b_0h", 4'h4, 1'b1, acc[0] + 1);
    expect_strobe("b2b_0l", 4'h1, 1'b1, acc[0] + 4);
    expect_strobe("b2b_1h", 4'h4, 1'b1, acc[1] + 1);
    expect_strobe("b2b_1l", 4'h2, 1'b1, acc[1] + 4);
    expect_strobe("b2b_2h", 4'h4, 1'b1, acc[2] + 1);
    expect_strobe("b2b_2l", 4'h3, 1'b1, acc[2] + 4);
    clear_q();

    // din_valid pulse during EXEC is ignored
    din = 8'h20; din_rs = 1'b1; din_valid = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_cyc(a + 20);
    check("pulse_ready", 32'(din_ready), 32'd0);
    din = 8'h55; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (!din_ready && n < 5000) begin @(negedge clk); n++; end
    check("pulse_gap", 32'(cyc + 1 - a), 32'(FAST_GAP));
    repeat (10) @(negedge clk);
    check("pulse_strobes", 32'(nib_q.size()), 32'd2);
    clear_q();

    // reset while E is high
    din = 8'h48; din_rs = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 20) begin @(negedge clk); n++; end
    check("mid_e_seen", 32'(lcd_e), 32'd1);
    nreset = 1'b0;
    #1;
    check("mid_e", 32'(lcd_e), 32'd0);
    check("mid_data", 32'(lcd_data), 32'd0);
    check("mid_rs", 32'(lcd_rs), 32'd0);
    check("mid_ready", 32'(din_ready), 32'd0);
    check("mid_done", 32'(init_done), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_e_held", 32'(lcd_e), 32'd0);
    clear_q();
    nreset = 1'b1;
    check_init("reinit");

    // INIT_EN=0 instance: no strobes until its first byte
    check("noinit_idle_strobes", 32'(e0_rises), 32'd0);
    din0 = 8'h31; din0_rs = 1'b1; din0_valid = 1'b1;
    @(negedge clk);
    din0_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("noinit_strobes", 32'(e0_rises), 32'd2);
    check("noinit_last_nib", 32'(lcd0_data), 32'h1);
    repeat (FAST_GAP) @(negedge clk);
    check("noinit_ready_back", 32'(din0_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
